// File: rtl/rv_fetch_queue.sv
// Instruction fetch stage: issues word reads on the instruction bus and buffers
// {pc, instr} pairs in a small FIFO that feeds decode.
module rv_fetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pc_change,
  input  logic [31:0] i_pc_target,
  input  logic        i_stall,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_data,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [31:0] RESET_PC = {RESET_ADDR[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t           state;
  logic             bus_req;
  logic [31:0]      bus_addr;
  logic [31:0]      fetch_pc;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  logic [31:0]      target;
  logic [31:0]      addr_inc;

  // A redirect always wins: it blocks both push and pop and empties the queue.
  always_comb begin
    target     = {i_pc_target[31:2], 2'b00};
    addr_inc   = bus_addr + 32'd4;
    push       = (state == FETCH) && i_bus_ack && !i_pc_change;
    pop        = (count != '0) && !i_stall && !i_pc_change;
    count_next = count;
    if (i_pc_change)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (pop && !push)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (i_pc_change) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= bus_addr;
          instr_mem[wr_ptr] <= i_bus_data;
          wr_ptr            <= wr_ptr + PTR_W'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Entering FETCH only with count < DEPTH reserves a slot for the response;
  // DISCARD keeps the old request alive until the slave acks it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      bus_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (i_pc_change) begin
            state    <= FETCH;
            bus_req  <= 1'b1;
            bus_addr <= target;
            fetch_pc <= target;
          end else if (count < FULL) begin
            state    <= FETCH;
            bus_req  <= 1'b1;
            bus_addr <= fetch_pc;
          end
        end
        FETCH: begin
          if (i_bus_ack && i_pc_change) begin
            bus_addr <= target;
            fetch_pc <= target;
          end else if (i_bus_ack) begin
            fetch_pc <= addr_inc;
            bus_addr <= addr_inc;
            if (count_next >= FULL) begin
              state   <= IDLE;
              bus_req <= 1'b0;
            end
          end else if (i_pc_change) begin
            state    <= DISCARD;
            fetch_pc <= target;
          end
        end
        DISCARD: begin
          if (i_bus_ack) begin
            state    <= FETCH;
            bus_addr <= i_pc_change ? target : fetch_pc;
            if (i_pc_change)
              fetch_pc <= target;
          end else if (i_pc_change) begin
            fetch_pc <= target;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_bus_req  = bus_req;
  assign o_bus_addr = bus_addr;
  assign o_valid    = (count != '0);
  assign o_pc       = pc_mem[rd_ptr];
  assign o_instr    = instr_mem[rd_ptr];

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Scoreboard bench for rv_fetch_queue: directed per-cycle stimulus pushes the
// expected bus handshakes and decode pops; a negedge monitor pops and compares.
module tb_rv_fetch_queue;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_pc_change;
  logic [31:0] i_pc_target;
  logic        i_stall;
  logic        o_bus_req;
  logic [31:0] o_bus_addr;
  logic        i_bus_ack;
  logic [31:0] i_bus_data;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_head_q [$];
  logic [63:0] exp_head;

  always #5 i_clk = ~i_clk;

  rv_fetch_queue #(
    .RESET_ADDR(32'h0000_0100),
    .DEPTH     (4)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_pc_change(i_pc_change),
    .i_pc_target(i_pc_target),
    .i_stall    (i_stall),
    .o_bus_req  (o_bus_req),
    .o_bus_addr (o_bus_addr),
    .i_bus_ack  (i_bus_ack),
    .i_bus_data (i_bus_data),
    .o_valid    (o_valid),
    .o_instr    (o_instr),
    .o_pc       (o_pc)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after a posedge; the slave answers with addr^0xA5A50000.
  task automatic applyStimulus(input logic ack, input logic stall, input logic chg,
                               input logic [31:0] tgt);
    i_bus_ack   = ack;
    i_stall     = stall;
    i_pc_change = chg;
    i_pc_target = tgt;
    i_bus_data  = o_bus_addr ^ 32'hA5A5_0000;
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    i_reset_n = 1'b1;
  endtask

  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_bus_req && i_bus_ack) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL bus_handshake: unexpected ack at addr 0x%08h, expected none", o_bus_addr);
        end else begin
          checkOutput("bus_handshake_addr", o_bus_addr, exp_addr_q.pop_front());
        end
      end
      if (o_valid && !i_stall && !i_pc_change) begin
        if (exp_head_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL decode_pop: unexpected pop pc=0x%08h instr=0x%08h, expected none", o_pc, o_instr);
        end else begin
          exp_head = exp_head_q.pop_front();
          checkOutput("pop_pc", o_pc, exp_head[63:32]);
          checkOutput("pop_instr", o_instr, exp_head[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset_n   = 1'b0;
    i_pc_change = 1'b0;
    i_pc_target = 32'h0;
    i_stall     = 1'b0;
    i_bus_ack   = 1'b0;
    i_bus_data  = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_bus_req", 32'(o_bus_req), 32'd0);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_bus_addr", o_bus_addr, 32'h0000_0100);
    checkOutput("reset_pc", o_pc, 32'h0);
    checkOutput("reset_instr", o_instr, 32'h0);

    // Streaming fetch under a held stall fills the queue, then stops requesting.
    i_reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("first_req", 32'(o_bus_req), 32'd1);
    checkOutput("first_addr", o_bus_addr, 32'h0000_0100);
    exp_addr_q.push_back(32'h0000_0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("first_valid", 32'(o_valid), 32'd1);
    checkOutput("first_head_pc", o_pc, 32'h0000_0100);
    checkOutput("first_head_instr", o_instr, 32'hA5A5_0100);
    checkOutput("addr_seq_104", o_bus_addr, 32'h0000_0104);
    exp_addr_q.push_back(32'h0000_0104);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("addr_seq_108", o_bus_addr, 32'h0000_0108);
    exp_addr_q.push_back(32'h0000_0108);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("addr_seq_10c", o_bus_addr, 32'h0000_010C);
    exp_addr_q.push_back(32'h0000_010C);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("full_req_low", 32'(o_bus_req), 32'd0);
    checkOutput("full_head_pc", o_pc, 32'h0000_0100);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("full_req_still_low", 32'(o_bus_req), 32'd0);
    exp_head_q.push_back({32'h0000_0100, 32'hA5A5_0100});
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("after_pop_head_pc", o_pc, 32'h0000_0104);
    checkOutput("after_pop_req", 32'(o_bus_req), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("refill_req", 32'(o_bus_req), 32'd1);
    checkOutput("refill_addr", o_bus_addr, 32'h0000_0110);
    exp_addr_q.push_back(32'h0000_0110);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("refill_single_req", 32'(o_bus_req), 32'd0);
    checkOutput("refill_valid", 32'(o_valid), 32'd1);

    // Redirect while a request is pending: old request drained, data dropped.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("r2_addr_100", o_bus_addr, 32'h0000_0100);
    exp_addr_q.push_back(32'h0000_0100);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    exp_head_q.push_back({32'h0000_0100, 32'hA5A5_0100});
    exp_addr_q.push_back(32'h0000_0104);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    exp_head_q.push_back({32'h0000_0104, 32'hA5A5_0104});
    exp_addr_q.push_back(32'h0000_0108);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("pending_addr", o_bus_addr, 32'h0000_010C);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_2002);
    checkOutput("flush_valid", 32'(o_valid), 32'd0);
    checkOutput("discard_req", 32'(o_bus_req), 32'd1);
    checkOutput("discard_addr_1", o_bus_addr, 32'h0000_010C);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("discard_addr_2", o_bus_addr, 32'h0000_010C);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("discard_addr_3", o_bus_addr, 32'h0000_010C);
    exp_addr_q.push_back(32'h0000_010C);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("discard_dropped_valid", 32'(o_valid), 32'd0);
    checkOutput("redirect_addr", o_bus_addr, 32'h0000_2000);

    // Redirect coincident with an ack and a would-be pop.
    exp_addr_q.push_back(32'h0000_2000);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redirect_head_valid", 32'(o_valid), 32'd1);
    checkOutput("redirect_head_pc", o_pc, 32'h0000_2000);
    exp_addr_q.push_back(32'h0000_2004);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_3000);
    checkOutput("ack_flush_valid", 32'(o_valid), 32'd0);
    checkOutput("ack_flush_addr", o_bus_addr, 32'h0000_3000);

    // Two redirects while discarding: only the last target is fetched.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0300);
    checkOutput("double_discard_addr", o_bus_addr, 32'h0000_3000);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0400);
    exp_addr_q.push_back(32'h0000_3000);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("resume_addr_400", o_bus_addr, 32'h0000_0400);
    exp_addr_q.push_back(32'h0000_0400);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    exp_head_q.push_back({32'h0000_0400, 32'hA5A5_0400});
    exp_addr_q.push_back(32'h0000_0404);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    exp_addr_q.push_back(32'h0000_0408);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset during FETCH with two entries queued.
    checkOutput("pre_reset_valid", 32'(o_valid), 32'd1);
    checkOutput("pre_reset_addr", o_bus_addr, 32'h0000_040C);
    i_reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_reset_req", 32'(o_bus_req), 32'd0);
    checkOutput("mid_reset_valid", 32'(o_valid), 32'd0);
    checkOutput("mid_reset_addr", o_bus_addr, 32'h0000_0100);

    // Address wrap from the top of memory.
    i_reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_addr_top", o_bus_addr, 32'hFFFF_FFFC);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr_zero", o_bus_addr, 32'h0000_0000);
    exp_head_q.push_back({32'hFFFF_FFFC, 32'h5A5A_FFFC});
    exp_addr_q.push_back(32'h0000_0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    exp_head_q.push_back({32'h0000_0000, 32'hA5A5_0000});
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("drained_valid", 32'(o_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    checkOutput("addr_queue_left", 32'(exp_addr_q.size()), 32'd0);
    checkOutput("head_queue_left", 32'(exp_head_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
